// File: rtl/dwa_scheduler_pkg.sv
// Shared types and constants for the DWA unit-element scheduler.
// Defines the FSM state encoding and the fixed element, code and pointer widths.
package dwa_scheduler_pkg;

   localparam int NELEM_C = 15;
   localparam int CODE_W  = 4;
   localparam int PTR_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

endpackage : dwa_scheduler_pkg

// File: rtl/dwa_rotmask.sv
// Combinational mask generator: N consecutive elements starting at ptr, modulo 15,
// or a thermometer anchored at element 0 when rotation is disabled.
module dwa_rotmask
   import dwa_scheduler_pkg::*;
#(
   parameter int ROTATE_EN = 1
) (
   input  logic [PTR_W-1:0]   ptr_i,
   input  logic [CODE_W-1:0]  n_i,
   output logic [NELEM_C-1:0] mask_o
);

   localparam logic [NELEM_C-1:0] ALL_ONES_C = 15'h7FFF;

   logic [NELEM_C-1:0]   therm_s;
   logic [2*NELEM_C-1:0] dbl_s;

   // Build the thermometer, then rotate it by folding a double-width shift back onto 15 bits
   always_comb begin
      therm_s = ALL_ONES_C >> (4'd15 - n_i);
      dbl_s   = {15'd0, therm_s} << ptr_i;
      if (ROTATE_EN != 0) begin
         mask_o = dbl_s[NELEM_C-1:0] | dbl_s[2*NELEM_C-1:NELEM_C];
      end else begin
         mask_o = therm_s;
      end
   end

endmodule : dwa_rotmask

// File: rtl/dwa_scheduler.sv
// Data-weighted-averaging scheduler: buffers one 4-bit level and, on each DAC tick,
// drives that many unit elements starting at a rotating pointer.
module dwa_scheduler
   import dwa_scheduler_pkg::*;
#(
   parameter int ROTATE_EN = 1,
   parameter int NELEM     = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              tick,
   input  logic              code_valid,
   input  logic [CODE_W-1:0] code,
   output logic              code_ready,
   output logic [NELEM-1:0]  elem_on,
   output logic [PTR_W-1:0]  ptr,
   output logic              underrun
);

   state_e              state_q;
   logic                full_q;
   logic [CODE_W-1:0]   buf_q;
   logic [NELEM-1:0]    elem_q;
   logic [PTR_W-1:0]    ptr_q;
   logic                underrun_q;

   logic                xfer_s;
   logic                consume_s;
   logic [PTR_W:0]      sum_s;
   logic [PTR_W-1:0]    ptr_d;
   logic [NELEM_C-1:0]  mask_s;

   // A tick frees the buffer in the same cycle, so a new code may land alongside it
   assign code_ready = (state_q != ST_IDLE) && (!full_q || tick);

   dwa_rotmask #(
      .ROTATE_EN (ROTATE_EN)
   ) u_rotmask (
      .ptr_i  (ptr_q),
      .n_i    (buf_q),
      .mask_o (mask_s)
   );

   // Handshake, consumption and modulo-15 pointer advance
   always_comb begin
      xfer_s    = code_valid && code_ready;
      consume_s = tick && full_q && (state_q != ST_IDLE);
      sum_s     = {1'b0, ptr_q} + {1'b0, buf_q};
      if (ROTATE_EN == 0) begin
         ptr_d = 4'd0;
      end else if (sum_s >= 5'd15) begin
         ptr_d = sum_s[PTR_W-1:0] - 4'd15;
      end else begin
         ptr_d = sum_s[PTR_W-1:0];
      end
   end

   // FSM, holding buffer, pointer and element-drive registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         full_q     <= 1'b0;
         buf_q      <= 4'd0;
         elem_q     <= '0;
         ptr_q      <= 4'd0;
         underrun_q <= 1'b0;
      end else if (!enable) begin
         state_q    <= ST_IDLE;
         full_q     <= 1'b0;
         buf_q      <= 4'd0;
         elem_q     <= '0;
         ptr_q      <= 4'd0;
         underrun_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: state_q <= ST_ARM;
            ST_ARM:  state_q <= consume_s ? ST_RUN : ST_ARM;
            ST_RUN:  state_q <= ST_RUN;
            default: state_q <= ST_IDLE;
         endcase

         if (consume_s) begin
            elem_q <= mask_s;
            ptr_q  <= ptr_d;
         end

         // An empty tick before the first code is expected and not an underrun
         if ((state_q == ST_RUN) && tick && !full_q) begin
            underrun_q <= 1'b1;
         end

         if (xfer_s) begin
            full_q <= 1'b1;
            buf_q  <= code;
         end else if (consume_s) begin
            full_q <= 1'b0;
         end
      end
   end

   assign elem_on  = elem_q;
   assign ptr      = ptr_q;
   assign underrun = underrun_q;

endmodule : dwa_scheduler

// File: tb/tb_dwa_scheduler.sv
// Directed self-checking bench for dwa_scheduler, with a rotating and a static instance
// driven from the same stimulus.
module tb_dwa_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        tick;
   logic        code_valid;
   logic [3:0]  code;
   logic        code_ready,   code_ready_s;
   logic [14:0] elem_on,      elem_on_s;
   logic [3:0]  ptr,          ptr_s;
   logic        underrun,     underrun_s;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   dwa_scheduler #(.ROTATE_EN(1), .NELEM(15)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick),
      .code_valid(code_valid), .code(code), .code_ready(code_ready),
      .elem_on(elem_on), .ptr(ptr), .underrun(underrun)
   );

   dwa_scheduler #(.ROTATE_EN(0), .NELEM(15)) dut_static (
      .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick),
      .code_valid(code_valid), .code(code), .code_ready(code_ready_s),
      .elem_on(elem_on_s), .ptr(ptr_s), .underrun(underrun_s)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] c);
      int n;
      n = 0;
      code_valid = 1'b1;
      code       = c;
      #1;
      while (!code_ready && n < 8) begin
         step();
         n++;
      end
      if (!code_ready) begin
         $display("FAIL push_timeout code_ready got %0b want 1", code_ready);
         total_cnt++;
      end
      step();
      code_valid = 1'b0;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; tick = 1'b0; code_valid = 1'b0; code = 4'd0;
      step(); step();
      if (elem_on !== 15'h0000) $display("FAIL rst_elem got %h want 0000", elem_on); else pass_cnt++;
      total_cnt++;
      if (ptr !== 4'd0) $display("FAIL rst_ptr got %0d want 0", ptr); else pass_cnt++;
      total_cnt++;
      if (underrun !== 1'b0) $display("FAIL rst_underrun got %0b want 0", underrun); else pass_cnt++;
      total_cnt++;
      if (code_ready !== 1'b0) $display("FAIL rst_ready got %0b want 0", code_ready); else pass_cnt++;
      total_cnt++;
      rst_n = 1'b1;
      step(); step();
      if (code_ready !== 1'b0) $display("FAIL idle_ready got %0b want 0", code_ready); else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_enable_first_code();
      enable = 1'b1;
      step();
      if (code_ready !== 1'b1) $display("FAIL arm_ready got %0b want 1", code_ready); else pass_cnt++;
      total_cnt++;
      push(4'd5);
      do_tick();
      if (elem_on !== 15'h001F) $display("FAIL first_elem got %h want 001f", elem_on); else pass_cnt++;
      total_cnt++;
      if (ptr !== 4'd5) $display("FAIL first_ptr got %0d want 5", ptr); else pass_cnt++;
      total_cnt++;
      step(); step(); step();
      if (elem_on !== 15'h001F || ptr !== 4'd5)
         $display("FAIL stable_between_ticks got %h/%0d want 001f/5", elem_on, ptr);
      else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_wrap();
      push(4'd8);
      do_tick();
      if (elem_on !== 15'h1FE0) $display("FAIL pre_wrap_elem got %h want 1fe0", elem_on); else pass_cnt++;
      total_cnt++;
      if (ptr !== 4'd13) $display("FAIL pre_wrap_ptr got %0d want 13", ptr); else pass_cnt++;
      total_cnt++;
      push(4'd4);
      do_tick();
      if (elem_on !== 15'h6003) $display("FAIL wrap_elem got %h want 6003", elem_on); else pass_cnt++;
      total_cnt++;
      if (ptr !== 4'd2) $display("FAIL wrap_ptr got %0d want 2", ptr); else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_extremes();
      push(4'd15);
      do_tick();
      if (elem_on !== 15'h7FFF) $display("FAIL n15_elem got %h want 7fff", elem_on); else pass_cnt++;
      total_cnt++;
      if (ptr !== 4'd2) $display("FAIL n15_ptr got %0d want 2", ptr); else pass_cnt++;
      total_cnt++;
      push(4'd0);
      do_tick();
      if (elem_on !== 15'h0000) $display("FAIL n0_elem got %h want 0000", elem_on); else pass_cnt++;
      total_cnt++;
      if (ptr !== 4'd2) $display("FAIL n0_ptr got %0d want 2", ptr); else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_underrun();
      push(4'd3);
      do_tick();
      if (elem_on !== 15'h001C || ptr !== 4'd5)
         $display("FAIL ur_setup got %h/%0d want 001c/5", elem_on, ptr);
      else pass_cnt++;
      total_cnt++;
      do_tick();
      if (underrun !== 1'b1) $display("FAIL ur_set got %0b want 1", underrun); else pass_cnt++;
      total_cnt++;
      if (elem_on !== 15'h001C || ptr !== 4'd5)
         $display("FAIL ur_hold got %h/%0d want 001c/5", elem_on, ptr);
      else pass_cnt++;
      total_cnt++;
      step(); step();
      push(4'd1);
      do_tick();
      if (elem_on !== 15'h0020 || ptr !== 4'd6)
         $display("FAIL ur_resume got %h/%0d want 0020/6", elem_on, ptr);
      else pass_cnt++;
      total_cnt++;
      if (underrun !== 1'b1) $display("FAIL ur_sticky got %0b want 1", underrun); else pass_cnt++;
      total_cnt++;
      enable = 1'b0;
      step();
      if (underrun !== 1'b0 || elem_on !== 15'h0000 || ptr !== 4'd0)
         $display("FAIL disable_clear got %0b/%h/%0d want 0/0000/0", underrun, elem_on, ptr);
      else pass_cnt++;
      total_cnt++;
      if (code_ready !== 1'b0) $display("FAIL disable_ready got %0b want 0", code_ready); else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_back_to_back();
      enable = 1'b1;
      step();
      do_tick();
      if (elem_on !== 15'h0000 || underrun !== 1'b0)
         $display("FAIL arm_empty_tick got %h/%0b want 0000/0", elem_on, underrun);
      else pass_cnt++;
      total_cnt++;
      push(4'd2);
      do_tick();
      if (elem_on !== 15'h0003 || ptr !== 4'd2)
         $display("FAIL b2b_setup got %h/%0d want 0003/2", elem_on, ptr);
      else pass_cnt++;
      total_cnt++;
      push(4'd3);
      tick = 1'b1; code_valid = 1'b1; code = 4'd7;
      #1;
      if (code_ready !== 1'b1) $display("FAIL b2b_ready got %0b want 1", code_ready); else pass_cnt++;
      total_cnt++;
      step();
      tick = 1'b0; code_valid = 1'b0;
      #1;
      if (elem_on !== 15'h001C || ptr !== 4'd5)
         $display("FAIL b2b_consume got %h/%0d want 001c/5", elem_on, ptr);
      else pass_cnt++;
      total_cnt++;
      if (code_ready !== 1'b0) $display("FAIL b2b_full got %0b want 0", code_ready); else pass_cnt++;
      total_cnt++;
      do_tick();
      if (elem_on !== 15'h0FE0 || ptr !== 4'd12)
         $display("FAIL b2b_stored got %h/%0d want 0fe0/12", elem_on, ptr);
      else pass_cnt++;
      total_cnt++;
      tick = 1'b1; code_valid = 1'b1; code = 4'd4;
      step();
      tick = 1'b0; code_valid = 1'b0;
      if (underrun !== 1'b1 || elem_on !== 15'h0FE0 || ptr !== 4'd12)
         $display("FAIL empty_xfer got %0b/%h/%0d want 1/0fe0/12", underrun, elem_on, ptr);
      else pass_cnt++;
      total_cnt++;
      do_tick();
      if (elem_on !== 15'h7001 || ptr !== 4'd1)
         $display("FAIL empty_xfer_next got %h/%0d want 7001/1", elem_on, ptr);
      else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_static();
      for (int i = 0; i < 2; i++) begin
         push(4'd6);
         do_tick();
         if (elem_on_s !== 15'h003F || ptr_s !== 4'd0)
            $display("FAIL static_%0d got %h/%0d want 003f/0", i, elem_on_s, ptr_s);
         else pass_cnt++;
         total_cnt++;
      end
      if (elem_on !== 15'h1F80 || ptr !== 4'd13)
         $display("FAIL rotate_pair got %h/%0d want 1f80/13", elem_on, ptr);
      else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      if (elem_on !== 15'h0000 || ptr !== 4'd0 || underrun !== 1'b0)
         $display("FAIL async_rst got %h/%0d/%0b want 0000/0/0", elem_on, ptr, underrun);
      else pass_cnt++;
      total_cnt++;
      if (code_ready !== 1'b0 || elem_on_s !== 15'h0000)
         $display("FAIL async_rst_aux got %0b/%h want 0/0000", code_ready, elem_on_s);
      else pass_cnt++;
      total_cnt++;
      step();
      rst_n = 1'b1;
      enable = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_enable_first_code();
      test_wrap();
      test_extremes();
      test_underrun();
      test_back_to_back();
      test_static();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_dwa_scheduler

// File: doc/dwa_scheduler.md
DWA_SCHEDULER -- requirements
Module: dwa_scheduler

Interface
REQ-001 Parameter ROTATE_EN, default 1, meaning 1 selects data-weighted-averaging rotation and 0 selects a static thermometer code anchored at element 0.
REQ-002 Parameter NELEM, default 15, is the unit-element count, fixed at 15; other values are unsupported.
REQ-003 clk  input  1  the single block clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  run enable; low forces IDLE.
REQ-006 tick  input  1  DAC update strobe, one clk wide, marks one output sample period.
REQ-007 code_valid  input  1  upstream 4-bit level is presented.
REQ-008 code  input  4  requested number of active unit elements, 0..15.
REQ-009 code_ready  output  1  the block accepts code this cycle.
REQ-010 elem_on  output  15  unit-element drive; bit i drives element i.
REQ-011 ptr  output  4  rotation pointer, 0..14.
REQ-012 underrun  output  1  sticky flag: a tick found no buffered code.

Function
REQ-013 An input transfer SHALL occur when code_valid and code_ready are both high on a rising clk edge.
REQ-014 A one-entry holding buffer SHALL store the transferred code and set the full flag.
REQ-015 code_ready SHALL equal (state != IDLE) and (not full or tick); this is combinational.
REQ-016 FSM states: IDLE, ARM (waiting for the first code), RUN.
- IDLE->ARM when enable=1.
- ARM->RUN on the first tick with full=1.
- Any state->IDLE when enable=0.
REQ-017 In ARM, a tick with full=0 SHALL be ignored; elem_on stays 0 and underrun is not set.
REQ-018 In RUN, a tick with full=1 SHALL consume the buffer on that edge.
- Starting at the next cycle, elem_on SHALL have bits ptr, ptr+1, ..., ptr+N-1 (mod 15) set, where N is the buffered code.
- ptr SHALL update to (ptr+N) mod 15.
- Latency from tick to elem_on/ptr change: 1 clk.
REQ-019 Modulo arithmetic: compute ptr+N in 5 bits and subtract 15 when the sum is 15 or more; result is 0..14.
REQ-020 Boundary N=0: elem_on=0, ptr unchanged. N=15: elem_on=all ones, ptr unchanged. Wrap-around: ptr=13, N=4 gives bits 13,14,0,1.
REQ-021 In RUN, a tick with full=0 SHALL hold elem_on and ptr unchanged and set underrun.
REQ-022 Simultaneous tick, full=1 and transfer: the old code is consumed and the new code is stored; full stays 1.
REQ-023 Simultaneous tick, full=0 and transfer: the new code is stored, not consumed, and counts as underrun.
REQ-024 ROTATE_EN=0: elem_on SHALL have bits 0..N-1 set and ptr SHALL stay 0.
REQ-025 Between ticks, elem_on and ptr SHALL be stable.
REQ-026 Entering IDLE (enable low, including mid-RUN) SHALL, on the next edge:
- clear elem_on, ptr, full and underrun;
- hold code_ready low while in IDLE.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, elem_on=0, ptr=0, full=0, buffered code=0 and underrun=0; code_ready is therefore 0.
REQ-028 Release of rst_n SHALL be synchronised externally; the block takes no action until the first edge with enable=1.

Structure
REQ-029 A shared package SHALL hold:
- the state enum (IDLE, ARM, RUN);
- NELEM_C=15;
- the 4-bit code and pointer widths.
REQ-030 One sub-module, dwa_rotmask, SHALL be purely combinational and map (ptr, N, ROTATE_EN) to the 15-bit mask.
REQ-031 The holding buffer, FSM and pointer register SHALL reside in dwa_scheduler.

Verification
REQ-032 Reset and enable:
- Stimulus: reset, then enable=1, code=5 valid, one tick.
- Required: elem_on=0x001F and ptr=5 one clk after the tick.
REQ-033 Wrap-around:
- Stimulus: from ptr=13, code=4 then tick.
- Required: elem_on=0x6003 and ptr=2.
REQ-034 Extremes:
- Stimulus: code=15 then tick, then code=0 then tick.
- Required: elem_on=0x7FFF with ptr unchanged, then elem_on=0x0000 with ptr unchanged.
REQ-035 Underrun:
- Stimulus: in RUN, a tick with no buffered code.
- Required: elem_on and ptr hold, underrun=1 and stays 1; enable low clears it.
REQ-036 Simultaneous events:
- Stimulus: full=1 (code 3), tick plus a new transfer of code 7 in the same cycle.
- Required: 3 elements on, ptr+=3, buffer holds 7.
REQ-037 Mid-operation stops:
- Stimulus: rst_n low asynchronously mid-RUN.
- Required: outputs 0 without waiting for a clock edge.
- Stimulus: ROTATE_EN=0 with codes 6 then 6.
- Required: elem_on=0x003F both times, ptr=0.
